// File: rtl/mux8way_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux8way_pkg : shared lane types and round-robin search helper            |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mux8way_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] lane_t;

  typedef struct packed {
    logic  found;
    lane_t idx;
  } pick_t;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then map back to a lane.
  function automatic pick_t rr_first(input logic [LANES-1:0] valid, input lane_t ptr);
    logic [2*LANES-1:0] dbl;
    pick_t              res;
    dbl = {valid, valid} >> ptr;
    res = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        res.found = 1'b1;
        res.idx   = ptr + lane_t'(k);
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux8way_arbiter_rr_pick8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick8 : combinational round-robin picker over eight request lines     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rr_pick8
  import mux8way_pkg::*;
(
  input  logic [LANES-1:0] valid,
  input  lane_t            ptr,
  output logic             found,
  output lane_t            idx,
  output logic [LANES-1:0] onehot
);

  pick_t w_pick;

  assign w_pick = rr_first(valid, ptr);
  assign found  = w_pick.found;
  assign idx    = w_pick.idx;
  assign onehot = w_pick.found ? ({{(LANES-1){1'b0}}, 1'b1} << w_pick.idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mux8way_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux8way_arbiter : eight-lane round-robin merger onto one tagged channel  |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module mux8way_arbiter
  import mux8way_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  lane_t            r_out_sel;
  lane_t            r_ptr;

  logic             w_load_en;
  logic             w_found;
  lane_t            w_idx;
  logic [LANES-1:0] w_onehot;
  logic [WIDTH-1:0] w_lane_data [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_unpack
    assign w_lane_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign w_load_en = !r_out_valid | out_ready;

  rr_pick8 u_pick (
    .valid  (in_valid),
    .ptr    (r_ptr),
    .found  (w_found),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  // Grant is gated by reset directly so nothing is offered while reset is held.
  assign in_ready = (w_load_en && !reset) ? w_onehot : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= '0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_lane_data[w_idx];
        r_out_sel   <= w_idx;
        r_ptr       <= w_idx + 3'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: doc/mux8way_arbiter.md
# mux8way_arbiter

Eight-lane round-robin merger: the gathering end of the `DMux8Way` distribution path. Up to eight producers offer WIDTH-bit words with valid/ready handshakes. One word per cycle is granted, registered, and forwarded on a single output channel. The channel is tagged with a 3-bit `out_sel` lane index, encoded exactly as the `sel` input of `DMux8Way`, so a downstream `DMux8Way` can route responses back to the originating lane.

## Interface
- `WIDTH`, default 16: data word width per lane (Hack word).
- `clk`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `in_valid`  input  8: per-lane word offered; bit i is lane i.
- `in_data`  input  8*WIDTH: lane i data on bits [i*WIDTH +: WIDTH].
- `in_ready`  output  8: one-hot (or zero) grant; lane i's word is taken on an edge where `in_valid[i] & in_ready[i]`.
- `out_valid`  output  1: output register holds a word.
- `out_data`  output  WIDTH: granted word.
- `out_sel`  output  3: lane index of `out_data`; 3'b000 is lane a, 3'b111 is lane h.
- `out_ready`  input  1: consumer accepts; transfer on `out_valid & out_ready`.

## Operation
- The output stage is a one-entry register with two states, EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
- `load_en = !out_valid | out_ready`.
- Round-robin pointer `ptr` (3 bits) names the highest-priority lane. Search order is ptr, ptr+1, … , ptr+7, all mod 8.
- Grant:
  - `in_ready[i]` = `load_en` & (i is the first lane in search order with `in_valid[i]`=1).
  - At most one bit of `in_ready` is set.
  - `in_ready` depends only on registered state and current inputs, with no combinational path from `in_data`.
- On a grant of lane i:
  - `out_data` ← lane i data.
  - `out_sel` ← i.
  - `out_valid` ← 1.
  - `ptr` ← i+1; 7 wraps to 0.
- If `load_en` is set and there is no grant, `out_valid` ← 0. `out_data`/`out_sel` hold their last values and are don't-care for checking.
- While FULL and `out_ready`=0:
  - `out_data`, `out_sel`, `out_valid` and `ptr` are stable.
  - `in_ready` = 0.
- A lane that drops `in_valid` without a transfer is legal and is simply not granted. Producers hold data stable while valid and not ready.
- `ptr` advances only on a grant, never while idle.

## Timing
- Latency is one cycle: a word granted at edge N appears on `out_*` after edge N.
- Throughput: one word per cycle when `out_ready`=1 continuously (simultaneous consume and load in FULL).
- Fairness: a continuously valid lane is granted within 8 grants.
- Reset (asynchronous assert, synchronous-safe release):
  - `out_valid`=0, `out_data`=0, `out_sel`=3'b000, `ptr`=0.
  - `in_ready` is forced to 8'h00 while `reset`=1.
- Reset mid-transfer drops the held word; no grant occurs on the releasing edge's cycle.
- Boundaries:
  - All eight lanes valid: grants cycle 0,1,…,7,0.
  - Only lane 7 valid after a lane-7 grant: `ptr` wraps to 0 and lane 7 is granted again.
  - Consume and load in the same cycle: no bubble.
  - `in_valid`=0 everywhere with `out_ready`=1: EMPTY after one edge.

## Structure
- Shared package `mux8way_pkg`:
  - `LANES=8`, `SEL_W=3`.
  - `lane_t` (3-bit index).
  - Function `rr_first(valid[7:0], ptr)` returns found flag + index.
- One combinational sub-module `rr_pick8` (inputs `valid`, `ptr`; outputs `found`, `idx`, `onehot`) performs the rotate / priority-encode / unrotate.
- The top holds the output register, `ptr` and handshake logic.
- Target is roughly 150–250 lines total.

## Test plan
- Reset with `in_valid`=8'hFF held during reset -> `in_ready`=0, `out_valid`=0, `out_sel`=0. After release, lane 0 is granted first.
- All lanes valid, lane i data = 16'h00A0+i, `out_ready`=1 for 10 cycles -> `out_sel` sequence 0,1,…,7,0,1 with matching data, and `out_valid` continuously 1.
- Only `in_valid`=8'h80 with `out_ready`=1 -> `out_sel`=7 every cycle, proving `ptr` wrap from 7 to 0 and back.
- Backpressure: lanes 2 and 5 valid, `out_ready`=0 for 4 cycles after the first load -> `out_sel`=2 and data held, `in_ready`=0. Raising `out_ready` gives 5 next, then 2.
- Single word on lane 3 (16'h1234), then idle with `out_ready`=1 -> `out_valid` high for exactly one cycle with `out_sel`=3'b011, then 0.
- Assert `reset` while FULL (lane 4, `out_ready`=0) -> `out_valid` drops immediately, without waiting for a clock edge. After release, `ptr`=0, so with lanes 4 and 1 valid, lane 1 is granted first.
